// File: rtl/systolic_array_2x2_pkg.sv
// Shared widths and PE indexing for the 2x2 output-stationary systolic array.
package systolic_array_2x2_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 12;
    localparam int FULL_W = ACC_W + 2 * DATA_W;

    // Bit positions of each PE inside the ovf vector: {PE11, PE10, PE01, PE00}.
    localparam int PE_00 = 0;
    localparam int PE_01 = 1;
    localparam int PE_10 = 2;
    localparam int PE_11 = 3;

    // Flattened index of PE(row, col); matches the ovf bit order.
    function automatic int pe_idx(input int row, input int col);
        return row * 2 + col;
    endfunction

endpackage

// File: rtl/systolic_array_2x2_if.sv
// Feeder -> MMU link: skewed operand streams in, accumulators and overflow flags back.
interface systolic_array_2x2_if;
    import systolic_array_2x2_pkg::*;

    logic                     clear;
    logic signed [DATA_W-1:0] a_data0;
    logic signed [DATA_W-1:0] a_data1;
    logic signed [DATA_W-1:0] b_data0;
    logic signed [DATA_W-1:0] b_data1;
    logic signed [ACC_W-1:0]  c00;
    logic signed [ACC_W-1:0]  c01;
    logic signed [ACC_W-1:0]  c10;
    logic signed [ACC_W-1:0]  c11;
    logic [3:0]               ovf;

    // Feeder side drives operands and clear, reads results.
    modport master (
        output clear, a_data0, a_data1, b_data0, b_data1,
        input  c00, c01, c10, c11, ovf
    );

    // Array side consumes operands every cycle and exposes its accumulators.
    modport slave (
        input  clear, a_data0, a_data1, b_data0, b_data1,
        output c00, c01, c10, c11, ovf
    );

endinterface

// File: rtl/systolic_array_2x2_pe.sv
// One processing element: registered MAC with wrap-around accumulator,
// sticky overflow flag, and right/down operand forwarding registers.
module systolic_pe
    import systolic_array_2x2_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [DATA_W-1:0] o_a,
    output logic signed [DATA_W-1:0] o_b,
    output logic signed [ACC_W-1:0]  o_acc,
    output logic                     o_ovf
);

    logic signed [DATA_W-1:0]   r_a;
    logic signed [DATA_W-1:0]   r_b;
    logic signed [ACC_W-1:0]    r_acc;
    logic                       r_ovf;

    logic signed [2*DATA_W-1:0] w_prod;
    logic [FULL_W-1:0]          w_acc_ext;
    logic [FULL_W-1:0]          w_prod_ext;
    logic [FULL_W-1:0]          w_sum;
    logic [FULL_W-ACC_W:0]      w_sum_top;
    logic                       w_fits;

    // Full-precision product and sum; the accumulator keeps only the low ACC_W bits.
    assign w_prod     = i_a * i_b;
    assign w_acc_ext  = {{(FULL_W - ACC_W){r_acc[ACC_W-1]}}, r_acc};
    assign w_prod_ext = {{(FULL_W - 2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_sum      = w_acc_ext + w_prod_ext;

    // The sum is representable only if every bit above the ACC_W sign bit copies it.
    assign w_sum_top  = w_sum[FULL_W-1:ACC_W-1];
    assign w_fits     = (&w_sum_top) | ~(|w_sum_top);

    // Accumulate and forward every cycle; clear wipes everything and drops this cycle's inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_clear) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= w_sum[ACC_W-1:0];
            r_ovf <= r_ovf | ~w_fits;
        end
    end

    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/systolic_array_2x2.sv
// 2x2 output-stationary systolic matrix multiplier: rows of W enter from the
// left, columns of X from the top; each PE owns one element of C = W x X.
module systolic_array_2x2
    import systolic_array_2x2_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    systolic_array_2x2_if.slave  i_mmu
);

    logic signed [DATA_W-1:0] w_a_row [2];
    logic signed [DATA_W-1:0] w_b_col [2];
    logic signed [DATA_W-1:0] w_a_in  [4];
    logic signed [DATA_W-1:0] w_b_in  [4];
    logic signed [DATA_W-1:0] w_a_out [4];
    logic signed [DATA_W-1:0] w_b_out [4];
    logic signed [ACC_W-1:0]  w_acc   [4];
    logic [3:0]               w_ovf;

    assign w_a_row[0] = i_mmu.a_data0;
    assign w_a_row[1] = i_mmu.a_data1;
    assign w_b_col[0] = i_mmu.b_data0;
    assign w_b_col[1] = i_mmu.b_data1;

    // Column 0 / row 0 take the external streams; the rest take the
    // registered operands of their left / upper neighbour.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_row
            for (gj = 0; gj < 2; gj++) begin : g_col
                localparam int P = gi * 2 + gj;

                if (gj == 0) begin : g_a_edge
                    assign w_a_in[P] = w_a_row[gi];
                end else begin : g_a_fwd
                    assign w_a_in[P] = w_a_out[gi * 2];
                end

                if (gi == 0) begin : g_b_edge
                    assign w_b_in[P] = w_b_col[gj];
                end else begin : g_b_fwd
                    assign w_b_in[P] = w_b_out[gj];
                end

                systolic_pe u_pe (
                    .clk     (clk),
                    .rst     (rst),
                    .i_clear (i_mmu.clear),
                    .i_a     (w_a_in[P]),
                    .i_b     (w_b_in[P]),
                    .o_a     (w_a_out[P]),
                    .o_b     (w_b_out[P]),
                    .o_acc   (w_acc[P]),
                    .o_ovf   (w_ovf[P])
                );
            end
        end
    endgenerate

    assign i_mmu.c00 = w_acc[pe_idx(0, 0)];
    assign i_mmu.c01 = w_acc[pe_idx(0, 1)];
    assign i_mmu.c10 = w_acc[pe_idx(1, 0)];
    assign i_mmu.c11 = w_acc[pe_idx(1, 1)];
    assign i_mmu.ovf = {w_ovf[PE_11], w_ovf[PE_10], w_ovf[PE_01], w_ovf[PE_00]};

endmodule

// File: tb/tb_systolic_array_2x2.sv
// Directed + randomized bench for systolic_array_2x2 against a matrix-level model.
module tb_systolic_array_2x2;
    import systolic_array_2x2_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    systolic_array_2x2_if bus ();

    systolic_array_2x2 dut (
        .clk   (clk),
        .rst   (rst),
        .i_mmu (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    // Model state: wrapped accumulator value and sticky overflow per PE (index row*2+col).
    int   m_acc [4];
    logic m_ovf [4];
    int   tw [2][2];
    int   tx [2][2];

    function automatic int wrap12(input int s);
        int r;
        r = ((s % 4096) + 4096) % 4096;
        if (r >= 2048) r = r - 4096;
        return r;
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 4; p++) begin
            m_acc[p] = 0;
            m_ovf[p] = 1'b0;
        end
    endtask

    // C[i][j] accumulates W[i][0]*X[0][j] first, then W[i][1]*X[1][j].
    task automatic model_feed();
        int s;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    s = m_acc[i*2+j] + tw[i][k] * tx[k][j];
                    if (s > 2047 || s < -2048) m_ovf[i*2+j] = 1'b1;
                    m_acc[i*2+j] = wrap12(s);
                end
    endtask

    task automatic chk_val(input string tag, input logic signed [ACC_W-1:0] got, input int exp_i);
        logic signed [ACC_W-1:0] e;
        e = ACC_W'(exp_i);
        vectors++;
        assert (got === e) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d", tag, got, e);
        end
    endtask

    task automatic chk_all(input string tag);
        logic [3:0] eo;
        eo = {m_ovf[3], m_ovf[2], m_ovf[1], m_ovf[0]};
        chk_val({tag, ".c00"}, bus.c00, m_acc[0]);
        chk_val({tag, ".c01"}, bus.c01, m_acc[1]);
        chk_val({tag, ".c10"}, bus.c10, m_acc[2]);
        chk_val({tag, ".c11"}, bus.c11, m_acc[3]);
        vectors++;
        assert (bus.ovf === eo) else begin
            errs++;
            $error("FAIL %s.ovf: got %b expected %b", tag, bus.ovf, eo);
        end
        $display("%s: c00=%0d c01=%0d c10=%0d c11=%0d ovf=%b", tag,
                 bus.c00, bus.c01, bus.c10, bus.c11, bus.ovf);
    endtask

    task automatic drive(input int a0, input int a1, input int b0, input int b1);
        bus.a_data0 = DATA_W'(a0);
        bus.a_data1 = DATA_W'(a1);
        bus.b_data0 = DATA_W'(b0);
        bus.b_data1 = DATA_W'(b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        bus.clear = 1'b0;
        model_clear();
    endtask

    // Feeds tw x tx with the feeder skew: E0, E1, E2, then a zero cycle for E3.
    task automatic feed(input string tag);
        drive(tw[0][0], 0, tx[0][0], 0);
        tick();
        drive(tw[0][1], tw[1][0], tx[1][0], tx[0][1]);
        tick();
        drive(0, tw[1][1], 0, tx[1][1]);
        tick();
        drive(0, 0, 0, 0);
        tick();
        model_feed();
        chk_all(tag);
    endtask

    task automatic set_mats(input int w00, input int w01, input int w10, input int w11,
                            input int x00, input int x01, input int x10, input int x11);
        tw[0][0] = w00; tw[0][1] = w01; tw[1][0] = w10; tw[1][1] = w11;
        tx[0][0] = x00; tx[0][1] = x01; tx[1][0] = x10; tx[1][1] = x11;
    endtask

    initial begin
        logic signed [7:0] r8;

        bus.clear = 1'b0;
        drive(0, 0, 0, 0);
        model_clear();

        // Reset state.
        tick();
        chk_all("reset");
        rst = 1'b0;

        // Async reset mid-stream, then release with clear held and nonzero inputs.
        set_mats(1, 2, 3, 4, 5, 6, 7, 8);
        drive(tw[0][0], 0, tx[0][0], 0);
        tick();
        drive(tw[0][1], tw[1][0], tx[1][0], tx[0][1]);
        tick();
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst");
        bus.clear = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            drive(7, -3, 11, 9);
            tick();
            chk_all("clear_hold");
        end
        bus.clear = 1'b0;
        drive(0, 0, 0, 0);
        tick();

        // Basic product with intermediate c00 after E0.
        do_clear();
        drive(1, 0, 5, 0);
        tick();
        chk_val("basic.e0_c00", bus.c00, 5);
        drive(2, 3, 7, 6);
        tick();
        drive(0, 4, 0, 8);
        tick();
        drive(0, 0, 0, 0);
        tick();
        set_mats(1, 2, 3, 4, 5, 6, 7, 8);
        model_feed();
        chk_all("basic");
        chk_val("basic.c11_lit", bus.c11, 50);

        // Signed operands.
        do_clear();
        set_mats(-1, 2, 3, -4, 5, -6, 7, 8);
        feed("signed");
        chk_val("signed.c10_lit", bus.c10, -13);

        // Overflow and wrap; flags stay set across idle cycles.
        do_clear();
        set_mats(127, 127, 127, 127, 127, 127, 127, 127);
        feed("ovf");
        chk_val("ovf.c00_lit", bus.c00, -510);
        for (int n = 0; n < 3; n++) tick();
        chk_all("ovf_sticky");
        do_clear();
        chk_all("ovf_cleared");

        // Clear colliding with E1: partial sums and pipeline contents dropped.
        set_mats(1, 2, 3, 4, 5, 6, 7, 8);
        drive(1, 0, 5, 0);
        tick();
        bus.clear = 1'b1;
        drive(2, 3, 7, 6);
        tick();
        bus.clear = 1'b0;
        model_clear();
        chk_all("clr_collide");
        drive(0, 0, 0, 0);
        feed("after_collide");

        // Two tiles accumulated without clear.
        do_clear();
        set_mats(1, 2, 3, 4, 5, 6, 7, 8);
        feed("tile1");
        feed("tile2");
        chk_val("tile2.c00_lit", bus.c00, 38);

        // Randomized feeds, sometimes cleared, otherwise accumulating.
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 2) == 0) do_clear();
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    r8 = 8'($urandom);
                    tw[i][j] = int'(r8);
                    r8 = 8'($urandom);
                    tx[i][j] = int'(r8);
                end
            feed($sformatf("rand%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/systolic_array_2x2.md
Name: systolic_array_2x2

Overview:
- Weight-stationary-free, output-stationary 2x2 systolic matrix-multiply unit. It is the consumer end of the feeder->mmu interface.
- Accepts skewed operand streams a_data0/1 (rows, from the weight matrix) and b_data0/1 (columns, from the input matrix). Each PE multiply-accumulates locally and forwards operands right and down.
- Exposes the four accumulators c00..c11 back to the feeder for saturation and host readout.
- Computes C = W x X for 2x2 signed int8 matrices.

Parameters:
- DATA_W, 8, operand width; signed two's complement.
- ACC_W, 12, accumulator width; results wrap modulo 2^ACC_W.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of all accumulators, pipeline registers and overflow flags.
- a_data0  in  DATA_W  row-0 operand, enters PE00.
- a_data1  in  DATA_W  row-1 operand, enters PE10.
- b_data0  in  DATA_W  column-0 operand, enters PE00.
- b_data1  in  DATA_W  column-1 operand, enters PE01.
- c00, c01, c10, c11  out  ACC_W each  signed accumulator of each PE, driven directly from the PE registers.
- ovf  out  4  sticky overflow flags, bit order {PE11, PE10, PE01, PE00}.

Behaviour:
- Reset (async, rst=1): c00..c11 = 0, ovf = 0, all forwarding registers = 0. Reset mid-computation discards all partial sums immediately.
- Grid and forwarding:
  - PE(i,j): a_in comes from a_data_i for j=0, else from the a_out register of PE(i,0). b_in comes from b_data_j for i=0, else from the b_out register of PE(0,j).
  - Each edge with clear=0: acc <= acc + sext(a_in*b_in); a_out <= a_in; b_out <= b_in.
- Arithmetic:
  - The product is full 2*DATA_W signed. The sum is formed at full precision (ACC_W+2*DATA_W bits), then truncated to ACC_W, which is two's-complement wrap.
  - ovf bit sets when the full-precision sum is not representable in ACC_W signed. It stays set until clear or rst.
- clear=1 at an edge: every acc, a_out, b_out and ovf goes to 0, and that cycle's inputs are dropped. Clear has priority over accumulate on simultaneous events.
- The feeder holds clear=1 while disabled, so the array idles at zero.
- Latency: let E0 be the edge sampling W0/X0 at PE00, with the feeder skew: E0 {a0=w0, b0=x0}; E1 {a0=w1, a1=w2, b0=x2, b1=x1}; E2 {a1=w3, b1=x3}.
  - c00 final after E1.
  - c01 and c10 final after E2.
  - c11 final after E3.
  - After E3, zero inputs keep all c values stable; a product with a zero operand adds 0.
- Continued accumulation without clear sums across successive matrix pairs. This is intended for K-tiling.
- No handshake. Operands are consumed every cycle unconditionally, and idle inputs must be 0.

Decomposition:
- Shared package: DATA_W and ACC_W defaults, and PE index constants for the ovf bit order.
- One sub-module: systolic_pe. It holds a registered MAC, a_out/b_out forwarding registers, and a sticky ovf.
- The top instantiates four PEs and wires the forwarding chain. The estimate is about 60 lines per PE plus about 80 lines for the top.

Test Plan:
- Reset/clear: assert rst mid-stream, then release with clear=1 -> all c = 0 and ovf = 0; c stays 0 while clear=1 even with nonzero inputs.
- Basic product: W=[[1,2],[3,4]], X=[[5,6],[7,8]], fed with the skew above -> after E3, c00=19, c01=22, c10=43, c11=50, ovf=0. Check the intermediate value c00=5 after E0.
- Signed: W=[[-1,2],[3,-4]], X=[[5,-6],[7,8]] -> c00=9, c01=22, c10=-13, c11=-50, ovf=0.
- Overflow/wrap: all W and X = 127 -> every c = -510 (32258 mod 4096 = 3586, read as signed); ovf=4'b1111 and sticky until clear.
- Clear collision: assert clear on E1 with nonzero inputs -> all c = 0 after E1. A subsequent full feed yields correct results with no residue from prior pipeline contents.
- Accumulate across tiles: feed the basic product twice without clear -> c00=38, c01=44, c10=86, c11=100.
